// File: rtl/motor_pkg.sv
// Shared types for the H-bridge PWM array.
// Channel states, direction codes and the state-to-pin map.
package motor_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    DEAD  = 3'd3,
    BRAKE = 3'd4
  } ch_state_t;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  typedef struct packed {
    logic a;
    logic b;
  } hb_pins_t;

  // Only BRAKE may drive both legs of the bridge.
  function automatic hb_pins_t pin_map(
    input ch_state_t st,
    input logic      dir,
    input logic      pwm
  );
    hb_pins_t p;
    p = '{a: 1'b0, b: 1'b0};
    case (st)
      RUN, DRAIN: begin
        p.a = (dir == DIR_FWD) & pwm;
        p.b = (dir == DIR_REV) & pwm;
      end
      BRAKE: begin
        p.a = 1'b1;
        p.b = 1'b1;
      end
      default: p = '{a: 1'b0, b: 1'b0};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/motor_pwm_channel.sv
// One H-bridge channel: soft-start ramp, reversal
// through a drain and dead period, and braking.
module motor_pwm_channel
  import motor_pkg::*;
#(
  parameter int DUTY_W    = 5,
  parameter int RAMP_STEP = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              tick,
  input  logic [DUTY_W-1:0] cnt,
  input  logic [DUTY_W-1:0] duty_cmd,
  input  logic              dir_cmd,
  input  logic              brake,
  output logic              motor_a,
  output logic              motor_b,
  output logic [DUTY_W-1:0] duty_now
);

  localparam bit LOAD =
    (RAMP_STEP <= 0) || (RAMP_STEP >= (1 << DUTY_W));
  localparam logic [DUTY_W-1:0] STEP =
    LOAD ? '0 : DUTY_W'(RAMP_STEP);

  function automatic logic [DUTY_W-1:0] ramp(
    input logic [DUTY_W-1:0] cur,
    input logic [DUTY_W-1:0] tgt
  );
    logic [DUTY_W-1:0] nxt;
    nxt = tgt;
    if (!LOAD) begin
      if (tgt > cur && tgt - cur > STEP)
        nxt = cur + STEP;
      else if (cur > tgt && cur - tgt > STEP)
        nxt = cur - STEP;
    end
    return nxt;
  endfunction

  ch_state_t         state;
  logic              dir_lat;
  hb_pins_t          pins;
  logic              pwm;
  logic [DUTY_W-1:0] ramp_run;
  logic [DUTY_W-1:0] ramp_down;
  logic [DUTY_W-1:0] ramp_up;

  assign pwm       = cnt < duty_now;
  assign ramp_run  = ramp(duty_now, duty_cmd);
  assign ramp_down = ramp(duty_now, '0);
  assign ramp_up   = ramp('0, duty_cmd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      dir_lat  <= DIR_FWD;
      duty_now <= '0;
      pins     <= '{a: 1'b0, b: 1'b0};
    end else if (brake) begin
      state    <= BRAKE;
      duty_now <= '0;
      pins     <= '{a: 1'b1, b: 1'b1};
    end else if (!enable) begin
      state    <= IDLE;
      duty_now <= '0;
      pins     <= '{a: 1'b0, b: 1'b0};
    end else begin
      pins <= pin_map(state, dir_lat, pwm);
      case (state)
        IDLE: begin
          duty_now <= '0;
          if (tick && duty_cmd != '0) begin
            state    <= RUN;
            dir_lat  <= dir_cmd;
            duty_now <= ramp_up;
          end
        end
        RUN: if (tick) begin
          if (dir_cmd != dir_lat) begin
            state    <= DRAIN;
            duty_now <= ramp_down;
          end else if (duty_cmd == '0 && duty_now == '0) begin
            state <= IDLE;
          end else begin
            duty_now <= ramp_run;
          end
        end
        // A late return of dir_cmd does not cut the drain short.
        DRAIN: if (tick) begin
          if (duty_now == '0) state <= DEAD;
          else duty_now <= ramp_down;
        end
        DEAD: if (tick) begin
          state    <= RUN;
          dir_lat  <= dir_cmd;
          duty_now <= ramp_up;
        end
        BRAKE: begin
          state    <= IDLE;
          duty_now <= '0;
        end
        default: begin
          state    <= IDLE;
          duty_now <= '0;
        end
      endcase
    end
  end

  assign motor_a = pins.a;
  assign motor_b = pins.b;

endmodule

// File: rtl/motor_pwm_array.sv
// Multi-channel H-bridge PWM driver sharing one
// prescaler and PWM period counter across all channels.
module motor_pwm_array
  import motor_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int DUTY_W    = 5,
  parameter int PRESC_DIV = 1024,
  parameter int RAMP_STEP = 2
) (
  input  logic                     clk_3125KHz,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [NUM_CH*DUTY_W-1:0] duty_cmd,
  input  logic [NUM_CH-1:0]        dir_cmd,
  input  logic [NUM_CH-1:0]        brake,
  output logic [NUM_CH-1:0]        motor_A,
  output logic [NUM_CH-1:0]        motor_B,
  output logic [NUM_CH*DUTY_W-1:0] duty_now,
  output logic                     period_tick
);

  localparam int PW =
    (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX =
    PW'(PRESC_DIV - 1);
  localparam logic [DUTY_W-1:0] CNT_MAX = '1;

  logic [PW-1:0]     presc;
  logic [DUTY_W-1:0] cnt;
  logic              presc_wrap;
  logic              period_end;

  assign presc_wrap = presc == PRESC_MAX;
  assign period_end = presc_wrap && cnt == CNT_MAX;

  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      presc       <= '0;
      cnt         <= '0;
      period_tick <= 1'b0;
    end else begin
      presc       <= presc_wrap ? '0 : presc + 1'b1;
      period_tick <= period_end;
      if (presc_wrap) cnt <= cnt + 1'b1;
    end
  end

  // Channels update on the wrap edge itself, so the new duty
  // is in force from the first count of the period.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    motor_pwm_channel #(
      .DUTY_W   (DUTY_W),
      .RAMP_STEP(RAMP_STEP)
    ) u_ch (
      .clk     (clk_3125KHz),
      .rst_n   (rst_n),
      .enable  (enable),
      .tick    (period_end),
      .cnt     (cnt),
      .duty_cmd(duty_cmd[i*DUTY_W +: DUTY_W]),
      .dir_cmd (dir_cmd[i]),
      .brake   (brake[i]),
      .motor_a (motor_A[i]),
      .motor_b (motor_B[i]),
      .duty_now(duty_now[i*DUTY_W +: DUTY_W])
    );
  end

endmodule

// File: tb/tb_motor_pwm_array.sv
// Bench for motor_pwm_array: per-tick duty scoreboard,
// per-period pin high-time counts, bridge overlap watch.
module tb_motor_pwm_array;

  localparam int NCH = 2;
  localparam int W   = 5;
  localparam int PD  = 2;
  localparam int PER = PD * 32;
  localparam logic [9:0] M0 = 10'h01F;
  localparam logic [9:0] M1 = 10'h3E0;
  localparam logic [9:0] MA = 10'h3FF;

  logic clk = 1'b0;
  logic rst_n;
  logic en1, en2;
  logic [NCH*W-1:0] duty1, duty2, dn1, dn2;
  logic [NCH-1:0] dir1, dir2, brk1, brk2;
  logic [NCH-1:0] A1, B1, A2, B2;
  logic tk1, tk2;

  always #5 clk = ~clk;

  motor_pwm_array #(
    .NUM_CH(NCH), .DUTY_W(W), .PRESC_DIV(PD), .RAMP_STEP(2)
  ) u_dut (
    .clk_3125KHz(clk), .rst_n(rst_n), .enable(en1),
    .duty_cmd(duty1), .dir_cmd(dir1), .brake(brk1),
    .motor_A(A1), .motor_B(B1), .duty_now(dn1),
    .period_tick(tk1)
  );

  motor_pwm_array #(
    .NUM_CH(NCH), .DUTY_W(W), .PRESC_DIV(PD), .RAMP_STEP(0)
  ) u_dut0 (
    .clk_3125KHz(clk), .rst_n(rst_n), .enable(en2),
    .duty_cmd(duty2), .dir_cmd(dir2), .brake(brk2),
    .motor_A(A2), .motor_B(B2), .duty_now(dn2),
    .period_tick(tk2)
  );

  typedef struct {
    logic [9:0] exp;
    logic [9:0] mask;
    int         id;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int ha[4];
  int hb[4];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d",
               name, act, req);
    end
  endtask

  function automatic logic [9:0] pk(input int d0, input int d1);
    logic [4:0] a, b;
    a = 5'(d0);
    b = 5'(d1);
    return {b, a};
  endfunction

  task automatic push(input int id, input logic [9:0] e,
                      input logic [9:0] m);
    exp_t x;
    x.exp = e;
    x.mask = m;
    x.id = id;
    q.push_back(x);
  endtask

  // Returns one negedge after the n-th tick, duty already applied.
  task automatic wait_ticks(input int n);
    int guard;
    for (int k = 0; k < n; k++) begin
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (!tk1 && guard < 3 * PER);
      if (!tk1) begin
        check("tick_timeout", guard, PER);
        return;
      end
      @(negedge clk);
    end
  endtask

  // Counts pin high time over exactly one period, ending like wait_ticks(1).
  task automatic run_period();
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      ha[i] = 0;
      hb[i] = 0;
    end
    forever begin
      for (int c = 0; c < NCH; c++) begin
        ha[c] += int'(A1[c]);
        hb[c] += int'(B1[c]);
        ha[2+c] += int'(A2[c]);
        hb[2+c] += int'(B2[c]);
      end
      if (tk1) break;
      n++;
      if (n > 3 * PER) begin
        check("period_timeout", n, PER);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    int gap;
    gap = -1;
    forever begin
      @(negedge clk);
      if (!rst_n) gap = -1;
      else if (gap >= 0) gap++;
      if (tk1) begin
        if (gap >= 0) check("tick_spacing", gap, PER);
        gap = 0;
        @(negedge clk);
        gap++;
        if (q.size() > 0) begin
          e = q.pop_front();
          check($sformatf("duty_t%0d", e.id),
                dn1 & e.mask, e.exp & e.mask);
        end
      end
    end
  end

  logic [1:0] bk_d1 = '0;
  logic [1:0] bk_d2 = '0;

  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      check("no_shoot_thru",
            A1[c] & B1[c] & ~(brk1[c] | bk_d1[c] | bk_d2[c]), 0);
      check("no_shoot_thru_r0", A2[c] & B2[c], 0);
    end
    bk_d2 <= bk_d1;
    bk_d1 <= brk1;
  end

  initial begin
    rst_n = 1'b0;
    en1 = 1'b0; duty1 = '0; dir1 = 2'b11; brk1 = '0;
    en2 = 1'b0; duty2 = '0; dir2 = 2'b11; brk2 = '0;
    repeat (3) @(negedge clk);
    check("rst_A", A1, 0);
    check("rst_B", B1, 0);
    check("rst_duty", dn1, 0);
    check("rst_tick", tk1, 0);
    check("rst_tick_r0", tk2, 0);

    // 1: soft start to 20 forward
    rst_n = 1'b1;
    en1 = 1'b1;
    duty1 = pk(20, 0);
    for (int k = 1; k <= 10; k++) push(1, pk(2 * k, 0), MA);
    push(1, pk(20, 0), MA);
    wait_ticks(10);
    run_period();
    check("t1_A0_high", ha[0], 20 * PD);
    check("t1_B0_high", hb[0], 0);
    check("t1_ch1_idle", ha[1] + hb[1], 0);

    // 2: reversal through drain and dead period
    dir1[0] = 1'b0;
    for (int d = 18; d >= 0; d -= 2) push(2, pk(d, 0), M0);
    push(2, pk(0, 0), M0);
    push(2, pk(2, 0), M0);
    push(2, pk(4, 0), M0);
    wait_ticks(11);
    run_period();
    check("t2_dead_A0", ha[0], 0);
    check("t2_dead_B0", hb[0], 0);
    run_period();
    check("t2_rev_B0", hb[0], 2 * PD);
    check("t2_rev_A0", ha[0], 0);

    // 3: brake on ch1
    duty1 = pk(20, 6);
    push(3, pk(0, 2), M1);
    push(3, pk(0, 4), M1);
    wait_ticks(2);
    repeat (10) @(negedge clk);
    brk1[1] = 1'b1;
    @(negedge clk);
    check("t3_brake_A1", A1[1], 1);
    check("t3_brake_B1", B1[1], 1);
    check("t3_brake_duty1", dn1[9:5], 0);
    repeat (3) @(negedge clk);
    brk1[1] = 1'b0;
    repeat (3) @(negedge clk);
    check("t3_idle_pins", {A1[1], B1[1]}, 0);
    push(3, pk(0, 2), M1);
    push(3, pk(0, 4), M1);
    wait_ticks(2);

    // 4: global disable mid-ramp
    repeat (10) @(negedge clk);
    en1 = 1'b0;
    @(negedge clk);
    check("t4_A", A1, 0);
    check("t4_B", B1, 0);
    check("t4_duty", dn1, 0);
    repeat (4) @(negedge clk);
    en1 = 1'b1;
    push(4, pk(2, 2), MA);
    push(4, pk(4, 4), MA);
    push(4, pk(6, 6), MA);
    wait_ticks(2);
    run_period();
    check("t4_rev_B0", hb[0], 4 * PD);
    check("t4_rev_A0", ha[0], 0);
    check("t4_fwd_A1", ha[1], 4 * PD);
    check("t4_fwd_B1", hb[1], 0);

    // 5: immediate load, full and zero duty
    en2 = 1'b1;
    duty2 = pk(31, 0);
    wait_ticks(1);
    check("t5_load31", dn2[4:0], 31);
    run_period();
    check("t5_A_full", ha[2], 31 * PD);
    check("t5_B_full", hb[2], 0);
    duty2 = pk(0, 0);
    wait_ticks(1);
    check("t5_load0", dn2[4:0], 0);
    run_period();
    check("t5_A_zero", ha[2], 0);
    check("t5_B_zero", hb[2], 0);

    // 6: async reset in DRAIN
    dir1[0] = 1'b1;
    wait_ticks(2);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_A", A1, 0);
    check("t6_B", B1, 0);
    check("t6_duty", dn1, 0);
    check("t6_tick", tk1, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push(6, pk(2, 2), MA);
    push(6, pk(4, 4), MA);
    wait_ticks(1);
    run_period();
    check("t6_fwd_A0", ha[0], 2 * PD);
    check("t6_fwd_B0", hb[0], 0);

    repeat (2) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
